// File: rtl/elevator_request_scheduler.sv
// ---------------------------------------------------------------------------
// elevator_request_scheduler
//
// Request scheduler and motion sequencer for a 3-floor elevator.
//
// Responsibilities:
//   - Latches button presses as pending requests.
//   - Picks a travel direction and keeps it while requests remain ahead of
//     the car, so floors are served in sweep order.
//   - Times travel between floors and the door dwell.
//   - Honours the emergency (SOS) and weight-limit inputs.
//
// Ports:
//   clk                   : divided system clock, all logic on rising edge
//   rst_n                 : synchronous reset, active-low
//   button_n[2:0]         : raw floor buttons, active-low; a press is a
//                           1->0 transition (bit0 = floor1 .. bit2 = floor3)
//   sos_mode              : emergency level, 1 = halt and freeze
//   weight_limit_exceeded : level, 1 = door must not close
//   led[2:0]              : pending-request indicators, one per floor
//   floor[2:0]            : one-hot current car position
//   door                  : 1 = door open
//   moving                : 1 = car travelling
//   dir_up                : current sweep direction, 1 = up
//
// Internal state is held in 'state' (state_t) for observation by checkers.
// ---------------------------------------------------------------------------
module elevator_request_scheduler #(
  parameter int MOVE_TICKS = 4,
  parameter int DOOR_TICKS = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] button_n,
  input  logic       sos_mode,
  input  logic       weight_limit_exceeded,
  output logic [2:0] led,
  output logic [2:0] floor,
  output logic       door,
  output logic       moving,
  output logic       dir_up
);

  localparam int MAX_TICKS = (MOVE_TICKS > DOOR_TICKS) ? MOVE_TICKS : DOOR_TICKS;
  localparam int CW        = $clog2(MAX_TICKS) + 1;

  localparam logic [CW-1:0] MOVE_LAST = CW'(MOVE_TICKS - 1);
  localparam logic [CW-1:0] DOOR_LAST = CW'(DOOR_TICKS - 1);
  localparam logic [CW-1:0] ONE       = CW'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE      = 2'd1,
    DOOR_OPEN = 2'd2,
    SOS       = 2'd3
  } state_t;

  state_t        state;
  logic [2:0]    hist;
  logic [CW-1:0] counter;

  logic [2:0] press;        // falling edges on button_n this cycle
  logic [2:0] here_press;   // presses for the floor the car is at
  logic [2:0] other_press;  // presses for any other floor
  logic [2:0] above;        // floors strictly above the car
  logic [2:0] below;        // floors strictly below the car
  logic       ahead;        // a request lies ahead in the current direction
  logic       shift_ok;     // one more floor exists in the current direction
  logic [2:0] next_floor;   // floor after one step in the current direction
  logic       serve_here;   // IDLE should open the door at this floor

  always_comb begin
    press       = hist & ~button_n;
    here_press  = press & floor;
    other_press = press & ~floor;

    above = {floor[1] | floor[0], floor[0], 1'b0};
    below = {1'b0, floor[2], floor[2] | floor[1]};
    ahead = dir_up ? |(led & above) : |(led & below);

    if (dir_up) begin
      shift_ok   = ~floor[2];
      next_floor = {floor[1:0], 1'b0};
    end else begin
      shift_ok   = ~floor[0];
      next_floor = {1'b0, floor[2:1]};
    end

    serve_here = (|here_press) | (|(led & floor));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      hist    <= 3'b111;
      counter <= '0;
      led     <= 3'b000;
      floor   <= 3'b001;
      door    <= 1'b0;
      moving  <= 1'b0;
      dir_up  <= 1'b1;
    end else begin
      // History always follows the buttons, even while presses are ignored.
      hist <= button_n;

      if (sos_mode) begin
        // Freeze: floor holds, any partial move is thrown away.
        state   <= SOS;
        counter <= '0;
        led     <= 3'b000;
        door    <= 1'b0;
        moving  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (serve_here) begin
              state   <= DOOR_OPEN;
              door    <= 1'b1;
              counter <= '0;
              led     <= (led | other_press) & ~floor;
            end else if (|led) begin
              if (!ahead) dir_up <= ~dir_up;
              state   <= MOVE;
              moving  <= 1'b1;
              counter <= '0;
              led     <= led | other_press;
            end else begin
              led <= led | other_press;
            end
          end

          MOVE: begin
            // While travelling, a press for the floor being left is a real
            // request for later service, so every press is latched.
            if (counter == MOVE_LAST) begin
              counter <= '0;
              if (shift_ok) begin
                floor <= next_floor;
                if (|(led & next_floor)) begin
                  state  <= DOOR_OPEN;
                  door   <= 1'b1;
                  moving <= 1'b0;
                  led    <= (led | press) & ~next_floor;
                end else begin
                  led <= led | press;
                end
              end else begin
                // Defensive: never leave the shaft, turn around instead.
                dir_up <= ~dir_up;
                led    <= led | press;
              end
            end else begin
              counter <= counter + ONE;
              led     <= led | press;
            end
          end

          DOOR_OPEN: begin
            led <= led | other_press;
            if ((|here_press) || weight_limit_exceeded) begin
              counter <= '0;
            end else if (counter == DOOR_LAST) begin
              state   <= IDLE;
              door    <= 1'b0;
              counter <= '0;
            end else begin
              counter <= counter + ONE;
            end
          end

          SOS: begin
            state <= IDLE;
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// ---------------------------------------------------------------------------
// tb_elevator_request_scheduler
//
// Drives directed scenarios followed by randomized button / SOS / weight
// activity. A behavioural model (integer car position, request bit array,
// remaining-time bookkeeping) predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_elevator_request_scheduler;

  localparam int MOVE_TICKS = 4;
  localparam int DOOR_TICKS = 6;

  logic       clk;
  logic       rst_n;
  logic [2:0] button_n;
  logic       sos_mode;
  logic       weight_limit_exceeded;
  logic [2:0] led;
  logic [2:0] floor;
  logic       door;
  logic       moving;
  logic       dir_up;

  int tests_run = 0;
  int tests_failed = 0;

  elevator_request_scheduler #(
    .MOVE_TICKS(MOVE_TICKS),
    .DOOR_TICKS(DOOR_TICKS)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .button_n             (button_n),
    .sos_mode             (sos_mode),
    .weight_limit_exceeded(weight_limit_exceeded),
    .led                  (led),
    .floor                (floor),
    .door                 (door),
    .moving               (moving),
    .dir_up               (dir_up)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp_v);
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL %s at %0t: got %b expected %b", tag, $time, obs, exp_v);
    end
  endtask

  // ---------------- reference model ----------------
  // Car position as an integer 0..2, requests as a bit per floor.
  // m_elapsed counts cycles spent in the current travel leg or dwell.
  int   m_pos;
  bit   m_req [3];
  bit   m_hist [3];
  bit   m_open;
  bit   m_travel;
  bit   m_up;
  bit   m_frozen;
  int   m_elapsed;
  bit   chk_en = 1'b0;

  function automatic bit any_req_between(int lo, int hi);
    bit r = 1'b0;
    for (int j = lo; j <= hi; j++) if (j >= 0 && j <= 2 && m_req[j]) r = 1'b1;
    return r;
  endfunction

  always @(posedge clk) begin
    bit pressed [3];
    bit old_req [3];
    bit any_old;
    bit restart;
    int np;
    chk_en <= 1'b1;
    if (!rst_n) begin
      m_pos = 0; m_open = 0; m_travel = 0; m_up = 1; m_frozen = 0; m_elapsed = 0;
      for (int i = 0; i < 3; i++) begin m_req[i] = 0; m_hist[i] = 1; end
    end else begin
      for (int i = 0; i < 3; i++) begin
        pressed[i] = m_hist[i] && !button_n[i];
        m_hist[i]  = button_n[i];
      end
      old_req = m_req;
      any_old = old_req[0] | old_req[1] | old_req[2];
      if (sos_mode) begin
        m_frozen = 1; m_open = 0; m_travel = 0; m_elapsed = 0;
        for (int i = 0; i < 3; i++) m_req[i] = 0;
      end else if (m_frozen) begin
        m_frozen = 0;
      end else if (m_open) begin
        restart = pressed[m_pos];
        for (int i = 0; i < 3; i++) if (pressed[i] && i != m_pos) m_req[i] = 1;
        if (restart || weight_limit_exceeded) m_elapsed = 0;
        else if (m_elapsed + 1 == DOOR_TICKS) begin m_open = 0; m_elapsed = 0; end
        else m_elapsed++;
      end else if (m_travel) begin
        for (int i = 0; i < 3; i++) if (pressed[i]) m_req[i] = 1;
        m_elapsed++;
        if (m_elapsed == MOVE_TICKS) begin
          m_elapsed = 0;
          np = m_up ? m_pos + 1 : m_pos - 1;
          if (np >= 0 && np <= 2) begin
            m_pos = np;
            if (old_req[np]) begin m_req[np] = 0; m_travel = 0; m_open = 1; end
          end else m_up = !m_up;
        end
      end else begin
        for (int i = 0; i < 3; i++) if (pressed[i] && i != m_pos) m_req[i] = 1;
        if (pressed[m_pos] || old_req[m_pos]) begin
          m_req[m_pos] = 0; m_open = 1; m_elapsed = 0;
        end else if (any_old) begin
          // Keep sweeping if something is still ahead, else turn around.
          m_req = old_req;
          if (m_up ? !any_req_between(m_pos + 1, 2) : !any_req_between(0, m_pos - 1))
            m_up = !m_up;
          for (int i = 0; i < 3; i++) if (pressed[i] && i != m_pos) m_req[i] = 1;
          m_travel = 1; m_elapsed = 0;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [2:0] e_floor;
    logic [2:0] e_led;
    if (chk_en) begin
      e_floor = 3'b000;
      e_floor[m_pos] = 1'b1;
      e_led = {m_req[2], m_req[1], m_req[0]};
      check("led",    led,             e_led);
      check("floor",  floor,           e_floor);
      check("door",   {2'b00, door},   {2'b00, m_open});
      check("moving", {2'b00, moving}, {2'b00, m_travel});
      check("dir_up", {2'b00, dir_up}, {2'b00, m_up});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [2:0] m);
    button_n = ~m;
    cyc(1);
    button_n = 3'b111;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    button_n = 3'b111;
    sos_mode = 1'b0;
    weight_limit_exceeded = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

    // Floor1 -> floor3 trip with door cycle.
    press(3'b100); cyc(25);
    // Back to floor1, then up with a late floor1 request behind the car.
    press(3'b001); cyc(30);
    press(3'b100); cyc(3);
    press(3'b001); cyc(45);
    // Door held at floor2 by the weight limit.
    press(3'b010); cyc(7);
    weight_limit_exceeded = 1'b1; cyc(20);
    weight_limit_exceeded = 1'b0; cyc(10);
    // SOS during a move; press during SOS is ignored.
    press(3'b100); cyc(3);
    sos_mode = 1'b1; cyc(2);
    press(3'b001); cyc(2);
    sos_mode = 1'b0; cyc(5);
    // Door-open restart at the current floor.
    press(3'b001); cyc(30);
    press(3'b001); cyc(5);
    press(3'b001); cyc(10);
    // Sweep order: car at floor2 heading up with floors 1 and 3 pending.
    press(3'b010); cyc(15);
    press(3'b101); cyc(50);

    // Randomized activity.
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 7) == 0) button_n = 3'($urandom_range(0, 7));
      else if ($urandom_range(0, 2) == 0) button_n = 3'b111;
      if (sos_mode) begin
        if ($urandom_range(0, 4) == 0) sos_mode = 1'b0;
      end else if ($urandom_range(0, 299) == 0) sos_mode = 1'b1;
      if ($urandom_range(0, 39) == 0) weight_limit_exceeded = ~weight_limit_exceeded;
      cyc(1);
    end

    // Mid-run reset.
    rst_n = 1'b0; cyc(2);
    rst_n = 1'b1; button_n = 3'b111; sos_mode = 1'b0;
    weight_limit_exceeded = 1'b0; cyc(3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
